// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the round-robin mux arbiter.
// The master side is the requester pool and the slave side is the arbiter.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  modport master (output req, input gnt, sel, busy);
  modport slave  (input req, output gnt, sel, busy);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that shares one 8:1 mux between eight requesters.
// It has a per-grant hold budget, and the mux select stays stable for the whole grant.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux8_rr_arbiter_if.slave   bus
);

  localparam int unsigned    HCW      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  // With an unlimited budget the counter is never used and stays at zero.
  localparam logic [HCW-1:0] HOLD_ONE = (MAX_HOLD == 0) ? '0 : HCW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [7:0]     gnt_q, gnt_d;
  logic [2:0]     sel_q, sel_d;
  logic           busy_q, busy_d;

  logic [7:0]     others;
  logic [2:0]     next_start;
  logic           issue;
  logic [2:0]     issue_idx;

  // First requester found when scanning start, start+1, ... start+7, all modulo 8.
  function automatic logic [2:0] rr_winner(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] w;
    logic       found;
    w     = start;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // NOTE: every signal gets its default value first, so no path leaves a value unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    others     = bus.req & ~(8'h01 << sel_q);
    next_start = sel_q + 3'd1;
    issue      = 1'b0;
    issue_idx  = 3'd0;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          issue     = 1'b1;
          issue_idx = rr_winner(bus.req, ptr_q);
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          ptr_d = next_start;
          if (|bus.req) begin
            issue     = 1'b1;
            issue_idx = rr_winner(bus.req, next_start);
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            busy_d  = 1'b0;
          end
        end else if (MAX_HOLD != 0 && hold_q == HOLD_MAX && |others) begin
          // The scan reaches the current grantee last, so one of the other requesters wins.
          ptr_d     = next_start;
          issue     = 1'b1;
          issue_idx = rr_winner(bus.req, next_start);
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d = GRANT;
      gnt_d   = 8'h01 << issue_idx;
      sel_d   = issue_idx;
      busy_d  = 1'b1;
      hold_d  = HOLD_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples
  // the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      hold_q  <= '0;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8-to-1 mux channel between eight requesters. It drives the mux select lines: sel[0]→s0, sel[1]→s1, sel[2]→s2. It also returns a one-hot grant to each requester. A grant can be held for several cycles, is limited by a hold budget, and rotates fairly so that no requester starves.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant while others are waiting; 0 means unlimited (grant released only when the request drops)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
req  input  8  request vector; req[i] = requester i wants the channel, held high for as long as it needs it
gnt  output  8  one-hot grant, registered; all-zero when idle
sel  output  3  binary index of current grantee, registered; drives mux s2..s0
busy  output  1  registered; 1 while any grant is active

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=8'h00, sel=3'd0, busy=0.
  - Internal pointer ptr=0, hold_cnt=0, state=IDLE.
  - Deassertion is seen at the next rising clk.
  - Reset mid-grant drops gnt immediately, with no completion cycle.
- Registers: ptr[2:0] (highest-priority candidate) and hold_cnt (width clog2(MAX_HOLD+1), minimum 1 bit).
- Winner search: first i with req[i]=1, scanning ptr, ptr+1, …, ptr+7, all mod 8.
- State IDLE:
  - If req==0: stay IDLE; outputs unchanged (sel keeps its last value).
  - Else: next edge gnt=onehot(winner), sel=winner, busy=1, hold_cnt=1, go to GRANT.
  - Latency is 1 cycle from req sampled high to gnt high.
- State GRANT (current grantee g=sel):
  - Release: req[g]=0 sampled.
    - ptr←g+1 mod 8.
    - If any other req is set, grant the search winner from g+1 at the next edge. This is back-to-back with no idle cycle, and hold_cnt←1.
    - Otherwise: gnt←0, busy←0, state←IDLE; sel holds g.
  - Preempt: req[g]=1, MAX_HOLD≠0, hold_cnt==MAX_HOLD, and some other req[j]=1 (j≠g).
    - ptr←g+1 mod 8; grant the winner from g+1 at the next edge; hold_cnt←1.
    - The preempted requester keeps its request and re-enters normal rotation.
  - Hold: req[g]=1 and the preempt condition is false.
    - Grant stays; hold_cnt increments, saturating at MAX_HOLD.
    - With MAX_HOLD=0, hold_cnt stays 0.
- Invariants:
  - gnt is always zero or one-hot, with gnt[sel]=busy.
  - sel changes only on the edge where a new grant is issued.
  - The mux select is therefore stable for the whole grant.
- Simultaneous events:
  - Requests rising in the same cycle are resolved by the search order from ptr.
  - A release and a new request arriving in the same cycle are handled by the release rule above.
- Fairness bound: with MAX_HOLD=N and all eight requesting continuously, any requester waits at most 7·N cycles.
- Requests that drop before being granted are simply not selected; there is no latching.

Test Plan:
1. Reset then single request: rst_n low with req=8'hFF → gnt=0, sel=0, busy=0 asynchronously. Release reset, then req=8'h10 → next edge gnt=8'h10, sel=4, busy=1. Drop req → next edge gnt=0, busy=0, sel stays 4.
2. Rotation, MAX_HOLD=8, each requester drops after 2 granted cycles, req=8'hFF held from ptr=0 → sel sequence 0,1,2,…,7,0, each 2 cycles, no idle gaps, gnt always one-hot.
3. Preemption, MAX_HOLD=4: req[2] held high forever while granted, req[5] raised at cycle 1 of the grant → gnt=8'h04 for exactly 4 cycles, then gnt=8'h20/sel=5. When req[5] drops, grant returns to 2.
4. No contention: MAX_HOLD=4, only req[3] high for 20 cycles → gnt=8'h08 for all 20 cycles, hold_cnt saturates at 4, no spurious release.
5. Wrap-around: grantee 7 releases while req=8'h03 → next grant sel=0 (ptr wrapped to 0), not 1.
6. Async reset mid-grant: during an active grant on sel=6, pulse rst_n low between edges → gnt=0 and busy=0 immediately. After release with req=8'h41, the first grant is sel=0 (ptr reset to 0).
